// File: rtl/psola_pkg.sv
// Shared constants and types for the PSOLA playback stage.
package psola_pkg;

    localparam int WINDOW_SIZE     = 2048;
    localparam int LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE);
    localparam int FRAC_BITS       = 10;
    localparam int SAMPLE_WIDTH    = 16;

    // Playback BRAM address: {bank, idx}; idx is wide enough for a 12-bit length.
    localparam int ADDR_W = LOG_WINDOW_SIZE + 2;
    localparam int IDX_W  = ADDR_W - 1;
    localparam int LEN_W  = 12;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } playback_state_t;

endpackage

// File: rtl/pipeline.sv
// Generic register pipeline: STAGES cycles of delay with synchronous clear.
module pipeline #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] data_q;
        if (gi == 0) begin : g_first
            // First stage captures the input word.
            always_ff @(posedge clk_i) begin
                if (rst_i) data_q <= '0;
                else       data_q <= d_i;
            end
        end else begin : g_rest
            // Later stages shift the previous stage forward.
            always_ff @(posedge clk_i) begin
                if (rst_i) data_q <= '0;
                else       data_q <= g_stage[gi-1].data_q;
            end
        end
    end

    assign q_o = g_stage[STAGES-1].data_q;

endmodule

// File: rtl/q_to_sample_sat.sv
// Combinational fixed-point to audio conversion: arithmetic shift then clamp.
module q_to_sample_sat
    import psola_pkg::*;
#(
    parameter int IN_W  = DATA_W,
    parameter int FRAC  = FRAC_BITS,
    parameter int OUT_W = SAMPLE_WIDTH
) (
    input  logic signed [IN_W-1:0]  q_i,
    output logic signed [OUT_W-1:0] sample_o
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] shifted;
    assign shifted = q_i >>> FRAC;

    // Clamp the integer part into the signed output range.
    always_comb begin
        sample_o = shifted[OUT_W-1:0];
        if (shifted > MAX_V)      sample_o = MAX_V[OUT_W-1:0];
        else if (shifted < MIN_V) sample_o = MIN_V[OUT_W-1:0];
    end

endmodule

// File: rtl/psola_playback.sv
// Double-buffered playback of finished PSOLA windows, one sample per tick,
// clearing each BRAM location after it is read.
module psola_playback
    import psola_pkg::*;
(
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           window_len_valid_in,
    input  logic [LEN_W-1:0]               window_len_in,
    input  logic                           sample_tick_in,
    output logic                           psola_bank_out,
    output logic [ADDR_W-1:0]              rd_addr_out,
    input  logic [DATA_W-1:0]              rd_data_in,
    output logic [ADDR_W-1:0]              clr_addr_out,
    output logic                           clr_we_out,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    output logic                           underrun_out,
    output logic                           overrun_out
);

    playback_state_t state_q, state_d;
    logic              play_bank_q, play_bank_d;
    logic              psola_bank_q, psola_bank_d;
    logic              pending_q, pending_d;
    logic [LEN_W-1:0]  pending_len_q, pending_len_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              req_valid_q, req_valid_d;
    logic              req_silence_q, req_silence_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;

    logic signed [SAMPLE_WIDTH-1:0] sample_q;
    logic                           sample_valid_q;

    logic [ADDR_W+1:0]              pipe_q;
    logic                           pipe_valid;
    logic                           pipe_silence;
    logic [ADDR_W-1:0]              pipe_addr;
    logic signed [SAMPLE_WIDTH-1:0] sat_sample;

    // Next-state logic: the tick is served against the current state first,
    // then an arriving window is applied on top of the post-tick state.
    always_comb begin
        state_d       = state_q;
        play_bank_d   = play_bank_q;
        psola_bank_d  = psola_bank_q;
        pending_d     = pending_q;
        pending_len_d = pending_len_q;
        len_d         = len_q;
        idx_d         = idx_q;
        rd_addr_d     = rd_addr_q;
        req_valid_d   = 1'b0;
        req_silence_d = 1'b0;
        underrun_d    = 1'b0;
        overrun_d     = 1'b0;

        if (sample_tick_in) begin
            req_valid_d = 1'b1;
            if (state_q == PLAY) begin
                if (idx_q < len_q) begin
                    rd_addr_d = {play_bank_q, idx_q};
                    idx_d     = idx_q + IDX_W'(1);
                end else if (pending_q) begin
                    play_bank_d  = psola_bank_q;
                    psola_bank_d = ~psola_bank_q;
                    len_d        = pending_len_q;
                    pending_d    = 1'b0;
                    if (pending_len_q != '0) begin
                        rd_addr_d = {psola_bank_q, {IDX_W{1'b0}}};
                        idx_d     = IDX_W'(1);
                    end else begin
                        idx_d         = '0;
                        req_silence_d = 1'b1;
                        underrun_d    = 1'b1;
                        state_d       = IDLE;
                    end
                end else begin
                    req_silence_d = 1'b1;
                    underrun_d    = 1'b1;
                    state_d       = IDLE;
                end
            end else begin
                req_silence_d = 1'b1;
                underrun_d    = 1'b1;
            end
        end

        if (window_len_valid_in) begin
            if (state_d == IDLE) begin
                play_bank_d  = psola_bank_d;
                psola_bank_d = ~psola_bank_d;
                len_d        = window_len_in;
                idx_d        = '0;
                pending_d    = 1'b0;
                state_d      = PLAY;
            end else begin
                overrun_d     = pending_d;
                pending_len_d = window_len_in;
                pending_d     = 1'b1;
            end
        end
    end

    // Control state and the first (address) stage of the read pipeline.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            play_bank_q   <= 1'b0;
            psola_bank_q  <= 1'b0;
            pending_q     <= 1'b0;
            pending_len_q <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            rd_addr_q     <= '0;
            req_valid_q   <= 1'b0;
            req_silence_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            play_bank_q   <= play_bank_d;
            psola_bank_q  <= psola_bank_d;
            pending_q     <= pending_d;
            pending_len_q <= pending_len_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            rd_addr_q     <= rd_addr_d;
            req_valid_q   <= req_valid_d;
            req_silence_q <= req_silence_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    // Two more stages so the request lines up with the BRAM read latency.
    pipeline #(
        .WIDTH  (ADDR_W + 2),
        .STAGES (2)
    ) u_pipe (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .d_i   ({req_valid_q, req_silence_q, rd_addr_q}),
        .q_o   (pipe_q)
    );

    assign {pipe_valid, pipe_silence, pipe_addr} = pipe_q;

    q_to_sample_sat u_sat (
        .q_i      ($signed(rd_data_in)),
        .sample_o (sat_sample)
    );

    // Output register: converted data for reads, zero for silence ticks.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= pipe_valid;
            if (pipe_valid) sample_q <= pipe_silence ? '0 : sat_sample;
        end
    end

    assign psola_bank_out   = psola_bank_q;
    assign rd_addr_out      = rd_addr_q;
    assign clr_addr_out     = pipe_addr;
    assign clr_we_out       = pipe_valid & ~pipe_silence;
    assign sample_out       = sample_q;
    assign sample_valid_out = sample_valid_q;
    assign underrun_out     = underrun_q;
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_psola_playback.sv
// Randomized bench for psola_playback with a queue-based reference model.
module tb_psola_playback;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        wvalid = 1'b0;
    logic [11:0] wlen = '0;
    logic        tick = 1'b0;
    logic        psola_bank;
    logic [12:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic [12:0] clr_addr;
    logic        clr_we;
    logic signed [15:0] sample;
    logic        sv, un, ov;

    always #5 clk = ~clk;

    psola_playback dut (
        .clk_in              (clk),
        .rst_in              (rst_in),
        .window_len_valid_in (wvalid),
        .window_len_in       (wlen),
        .sample_tick_in      (tick),
        .psola_bank_out      (psola_bank),
        .rd_addr_out         (rd_addr),
        .rd_data_in          (rd_data),
        .clr_addr_out        (clr_addr),
        .clr_we_out          (clr_we),
        .sample_out          (sample),
        .sample_valid_out    (sv),
        .underrun_out        (un),
        .overrun_out         (ov)
    );

    // BRAM model: two-cycle read latency, clear port writes zero.
    int mem [8192];
    int shadow [8192];
    int d1 = 0;
    int cyc = 0;

    always @(posedge clk) begin
        if (clr_we) mem[clr_addr] = 0;
        rd_data <= d1;
        d1 <= mem[rd_addr];
        cyc <= cyc + 1;
    end

    // Expected events per cycle (ring indexed by cycle number).
    localparam int R = 64;
    bit e_sv [R];
    int e_s  [R];
    bit e_cw [R];
    int e_ca [R];
    bit e_ra [R];
    int e_rv [R];
    bit e_un [R];
    bit e_ov [R];

    // Reference model state.
    bit m_active;
    int m_q[$];
    bit m_pend;
    int m_plen;
    bit m_pb;
    int dir_data[$];

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int q_sat(input int v);
        longint x, q;
        x = v;
        q = x / 1024;
        if (x < 0 && (x % 1024) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic int rand_val();
        int sel;
        sel = int'($urandom % 5);
        case (sel)
            0: return int'($urandom);
            1: return int'($urandom % 67108864) - 33554432;
            2: return int'($urandom % 8192) - 4096;
            3: return int'($urandom % 80000000) - 40000000;
            default: return ($urandom % 2 == 0) ? 32'sh7FFFFFFF : 32'sh80000000;
        endcase
    endfunction

    task automatic clear_slots();
        for (int i = 0; i < R; i++) begin
            e_sv[i] = 0; e_s[i] = 0; e_cw[i] = 0; e_ca[i] = 0;
            e_ra[i] = 0; e_rv[i] = 0; e_un[i] = 0; e_ov[i] = 0;
        end
    endtask

    task automatic fill(input bit bank, input int len);
        m_q.delete();
        for (int k = 0; k < len; k++) m_q.push_back(int'(bank) * 4096 + k);
    endtask

    task automatic model_tick(input int t);
        int a;
        bit rd;
        rd = 0;
        a = 0;
        if (m_active) begin
            if (m_q.size() == 0 && m_pend) begin
                fill(m_pb, m_plen);
                m_pb = !m_pb;
                m_pend = 0;
            end
            if (m_q.size() > 0) begin
                a = m_q.pop_front();
                rd = 1;
            end else begin
                m_active = 0;
            end
        end
        if (rd) begin
            e_ra[t % R] = 1;       e_rv[t % R] = a;
            e_cw[(t+2) % R] = 1;   e_ca[(t+2) % R] = a;
            e_sv[(t+3) % R] = 1;   e_s[(t+3) % R] = q_sat(shadow[a]);
        end else begin
            e_un[t % R] = 1;
            e_sv[(t+3) % R] = 1;   e_s[(t+3) % R] = 0;
        end
    endtask

    task automatic model_window(input int t, input int len);
        if (!m_active) begin
            fill(m_pb, len);
            m_pb = !m_pb;
            m_active = 1;
            m_pend = 0;
        end else begin
            if (m_pend) e_ov[t % R] = 1;
            m_plen = len;
            m_pend = 1;
        end
    endtask

    // Acts as the PSOLA writer: fills the bank it is currently pointed at.
    task automatic write_data(input int len);
        int v;
        for (int k = 0; k < len; k++) begin
            v = (dir_data.size() > 0) ? dir_data.pop_front() : rand_val();
            mem[int'(m_pb) * 4096 + k] = v;
            shadow[int'(m_pb) * 4096 + k] = v;
        end
    endtask

    task automatic check_slot();
        int i;
        int s;
        i = cyc % R;
        s = sample;
        check_val("sample_valid", int'(sv), int'(e_sv[i]));
        if (e_sv[i]) check_val("sample", s, e_s[i]);
        check_val("clr_we", int'(clr_we), int'(e_cw[i]));
        if (e_cw[i]) begin
            check_val("clr_addr", int'(clr_addr), e_ca[i]);
            shadow[e_ca[i]] = 0;
        end
        if (e_ra[i]) check_val("rd_addr", int'(rd_addr), e_rv[i]);
        check_val("underrun", int'(un), int'(e_un[i]));
        check_val("overrun", int'(ov), int'(e_ov[i]));
        check_val("psola_bank", int'(psola_bank), int'(m_pb));
        e_sv[i] = 0; e_cw[i] = 0; e_ra[i] = 0; e_un[i] = 0; e_ov[i] = 0;
    endtask

    task automatic do_cycle(input bit t, input bit w, input int len);
        bit old_pb;
        @(negedge clk);
        check_slot();
        old_pb = m_pb;
        if (t) model_tick(cyc + 1);
        // A window cannot coincide with a bank swap: its data would sit in the bank now playing.
        if (w && (m_pb == old_pb)) begin
            write_data(len);
            model_window(cyc + 1, len);
        end else begin
            w = 0;
        end
        tick   = t;
        wvalid = w;
        wlen   = len[11:0];
        $display("cyc=%0d tick=%0b win=%0b len=%0d sample=%0d valid=%0b", cyc, t, w, len, sample, sv);
    endtask

    task automatic tick_gap();
        do_cycle(1, 0, 0);
        repeat (3) do_cycle(0, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_active; k++) tick_gap();
        repeat (4) do_cycle(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_slot();
        rst_in = 1; tick = 0; wvalid = 0;
        clear_slots();
        m_active = 0; m_q.delete(); m_pend = 0; m_plen = 0; m_pb = 0;
        @(negedge clk);
        check_val("rst_rd_addr", int'(rd_addr), 0);
        check_val("rst_clr_addr", int'(clr_addr), 0);
        check_val("rst_clr_we", int'(clr_we), 0);
        check_val("rst_sample", int'(sample), 0);
        check_val("rst_valid", int'(sv), 0);
        check_val("rst_underrun", int'(un), 0);
        check_val("rst_overrun", int'(ov), 0);
        check_val("rst_psola_bank", int'(psola_bank), 0);
        $display("cyc=%0d reset applied", cyc);
        rst_in = 0;
    endtask

    initial begin
        int g, l;
        bit w;
        for (int i = 0; i < 8192; i++) begin mem[i] = 0; shadow[i] = 0; end
        clear_slots();
        m_active = 0; m_pend = 0; m_plen = 0; m_pb = 0;
        do_reset();

        // Ticks with no window: silence and underruns.
        repeat (3) tick_gap();
        repeat (2) do_cycle(0, 0, 0);

        // Simple window of three samples in bank 0.
        dir_data = '{1024, -2048, 5120};
        do_cycle(0, 1, 3);
        repeat (3) tick_gap();
        tick_gap();

        // Saturation corners.
        dir_data = '{32'sh7FFFFFFF, 32'sh80000000, 32'sh000003FF, 32'shFFFFFC00};
        do_cycle(0, 1, 4);
        repeat (5) tick_gap();

        // Pending window swapped in at end of current one.
        drain();
        do_cycle(0, 1, 2);
        do_cycle(1, 0, 0);
        dir_data = '{3072};
        do_cycle(0, 1, 1);
        repeat (2) do_cycle(0, 0, 0);
        repeat (3) tick_gap();

        // Overrun: second pending window replaces the first.
        drain();
        do_cycle(0, 1, 3);
        do_cycle(1, 0, 0);
        do_cycle(0, 1, 5);
        do_cycle(0, 1, 7);
        do_cycle(0, 0, 0);
        repeat (12) tick_gap();

        // Simultaneous tick and window.
        drain();
        do_cycle(1, 1, 2);
        repeat (3) do_cycle(0, 0, 0);
        do_cycle(1, 1, 3);
        repeat (3) do_cycle(0, 0, 0);
        repeat (6) tick_gap();

        // Randomized traffic.
        repeat (300) begin
            g = int'($urandom_range(4, 7));
            for (int c = 0; c < g; c++) begin
                w = ($urandom % 5 == 0);
                l = ($urandom % 12 == 0) ? 0 : int'($urandom_range(1, 6));
                do_cycle(c == 0, w, l);
            end
        end

        // Reset in the middle of a window.
        drain();
        do_cycle(0, 1, 3);
        do_cycle(1, 0, 0);
        do_cycle(0, 0, 0);
        for (int i = 0; i < 8192; i++) shadow[i] = mem[i];
        do_reset();
        repeat (10) do_cycle(0, 0, 0);
        repeat (2) tick_gap();
        repeat (6) do_cycle(0, 0, 0);

        // Every location that was played must have been cleared.
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 8192; i++) if (mem[i] != shadow[i]) bad++;
            check_val("mem_clean", bad, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
